hs_rr_arbiter: RTL and testbench
================================

HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of valid/ready source ports (2..8) SHALL be supported.
REQ-002 Parameter DW, default 8, data width per source SHALL be supported.
REQ-003 Parameter TIMEOUT, default 255, ack-wait cycle limit before error flag SHALL be supported.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 src_valid  input  NUM_SRC  per-source valid.
REQ-007 src_data  input  NUM_SRC*DW  packed source data, source i at bits [i*DW +: DW].
REQ-008 src_ready  output  NUM_SRC  per-source ready, one-hot or zero.
REQ-009 src_mask  input  NUM_SRC  1 = source enabled for arbitration.
REQ-010 req  output  1  4-phase request to downstream consumer.
REQ-011 ack  input  1  4-phase acknowledge, asynchronous to clk.
REQ-012 data_o  output  DW  data accompanying req.
REQ-013 src_id  output  clog2(NUM_SRC)  index of source whose data is on data_o.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 err_timeout  output  1  sticky ack-timeout flag.
REQ-016 err_clr  input  1  synchronous clear of err_timeout.

Function
REQ-017 ack SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized ack_s.
REQ-018 FSM states SHALL be IDLE, WAIT_ACK_HI, WAIT_ACK_LO.
REQ-019 IDLE: if ack_s==0 and any (src_valid & src_mask) set, the round-robin winner's src_ready SHALL be 1 combinationally; all other src_ready bits 0.
REQ-020 IDLE with ack_s==1: src_ready SHALL be all 0, no grant.
REQ-021 Round-robin search SHALL start at (last_grant+1) mod NUM_SRC, ascending with wrap; masked or non-valid sources skipped.
REQ-022 On the edge where src_valid[w]&src_ready[w]: data_r<=src_data[w], src_id<=w, last_grant<=w, req<=1, state->WAIT_ACK_HI.
REQ-023 WAIT_ACK_HI: req SHALL stay 1; on ack_s==1, req<=0 and state->WAIT_ACK_LO.
REQ-024 WAIT_ACK_LO: req SHALL stay 0; on ack_s==0, state->IDLE.
REQ-025 src_ready SHALL be 0 in WAIT_ACK_HI and WAIT_ACK_LO.
REQ-026 data_o SHALL equal data_r while req==1 and 0 while req==0; src_id SHALL hold its last value.
REQ-027 data_r SHALL be stable from req rise until req fall.
REQ-028 Minimum transfer: accept edge, req high next cycle; a new accept SHALL be possible no earlier than the first IDLE cycle after ack_s falls.
REQ-029 src_mask changes SHALL take effect at the next IDLE arbitration; an in-flight transfer SHALL never be aborted by mask.
REQ-030 A timeout counter SHALL count cycles in WAIT_ACK_HI, clear on entry; reaching TIMEOUT SHALL set err_timeout; the counter saturates; FSM SHALL keep waiting (no abort).
REQ-031 err_clr SHALL clear err_timeout; if set and clear coincide, set wins.
REQ-032 A source deasserting valid before being granted SHALL be legal; no data of that source captured.

Reset
REQ-033 During rstn low: state=IDLE, req=0, data_r=0, src_id=0, last_grant=NUM_SRC-1, err_timeout=0, timeout counter=0, synchronizer flops=0.
REQ-034 Reset mid-transfer SHALL drop req immediately (asynchronously) and discard data_r; after release, source 0 has top priority.

Verification
REQ-035 Single source: src_valid=0001, data 0xA5, ack looped back with 3-cycle delay -> one req pulse, data_o=0xA5, src_id=0, busy low after ack fall.
REQ-036 All four valid continuously, mask=1111 -> grant order 0,1,2,3,0 and src_id sequence matches; no source granted twice consecutively.
REQ-037 mask=1010, all valid -> only sources 1 and 3 granted, alternating.
REQ-038 ack held high at idle with valid=0001 -> src_ready stays 0000 until ack low, then grant source 0.
REQ-039 ack never rises, TIMEOUT=16 -> err_timeout set 16 cycles after req rise, req remains 1; err_clr pulse -> err_timeout 0 only if not re-set same cycle.
REQ-040 rstn pulse while req=1 -> req 0 asynchronously, busy 0; next grant with valid=1111 goes to source 0.

Source files
------------

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin arbiter moving valid/ready source words onto a 4-phase req/ack link
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   src_valid/src_ready  per-source handshake (ready is one-hot or zero)
//   src_data             packed source words, source i at [i*DW +: DW]
//   src_mask             1 = source takes part in arbitration
//   req/ack              4-phase link to the consumer (ack is asynchronous)
//   data_o, src_id       word on the link (zero while req low) and its source index
//   busy                 a transfer is in progress
//   err_timeout/err_clr  sticky ack-wait timeout flag and its synchronous clear
module hs_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DW = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*DW-1:0]      src_data,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC-1:0]         src_mask,
  output logic                       req,
  input  logic                       ack,
  output logic [DW-1:0]              data_o,
  output logic [$clog2(NUM_SRC)-1:0] src_id,
  output logic                       busy,
  output logic                       err_timeout,
  input  logic                       err_clr
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_ACK_HI, WAIT_ACK_LO} state_t;
  state_t state_q, state_d;
  logic ack_meta_q, ack_s_q;
  logic req_q, req_d;
  logic [DW-1:0] data_r_q, data_r_d;
  logic [IW-1:0] src_id_q, src_id_d, last_grant_q, last_grant_d, gnt_id, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [NUM_SRC-1:0] elig;
  logic gnt_ok;
  assign elig = src_valid & src_mask;
  // Search from last_grant+1 upward with wrap; iterating the offset downward
  // lets the nearest eligible source overwrite any farther one.
  always_comb begin
    gnt_id = '0;
    idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = IW'((int'(last_grant_q) + k) % NUM_SRC);
      if (elig[idx]) gnt_id = idx;
    end
  end
  assign gnt_ok    = state_q == IDLE && !ack_s_q && |elig;
  assign src_ready = gnt_ok ? NUM_SRC'(1) << gnt_id : '0;
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    data_r_d     = data_r_q;
    src_id_d     = src_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: if (gnt_ok) begin
        state_d      = WAIT_ACK_HI;
        req_d        = 1'b1;
        data_r_d     = src_data[gnt_id*DW +: DW];
        src_id_d     = gnt_id;
        last_grant_d = gnt_id;
        cnt_d        = '0;
      end
      WAIT_ACK_HI: begin
        cnt_d = cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
        if (ack_s_q) begin
          state_d = WAIT_ACK_LO;
          req_d   = 1'b0;
        end
      end
      default: if (!ack_s_q) state_d = IDLE;
    endcase
    // The flag fires once, on the cycle the counter reaches TIMEOUT; set beats clear.
    err_d = (state_q == WAIT_ACK_HI && cnt_q == CW'(TIMEOUT - 1)) | (err_q & ~err_clr);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_meta_q   <= 1'b0;
      ack_s_q      <= 1'b0;
      state_q      <= IDLE;
      req_q        <= 1'b0;
      data_r_q     <= '0;
      src_id_q     <= '0;
      last_grant_q <= IW'(NUM_SRC - 1);
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      ack_meta_q   <= ack;
      ack_s_q      <= ack_meta_q;
      state_q      <= state_d;
      req_q        <= req_d;
      data_r_q     <= data_r_d;
      src_id_q     <= src_id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end
  assign req         = req_q;
  assign data_o      = req_q ? data_r_q : '0;
  assign src_id      = src_id_q;
  assign busy        = state_q != IDLE;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb_hs_rr_arbiter: directed self-checking bench for hs_rr_arbiter
module tb_hs_rr_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] src_valid = '0;
  logic [31:0] src_data = '0;
  logic [3:0] src_ready;
  logic [3:0] src_mask = 4'hf;
  logic req;
  logic ack = 1'b0;
  logic [7:0] data_o;
  logic [1:0] src_id;
  logic busy;
  logic err_timeout;
  logic err_clr = 1'b0;
  int checks = 0;
  int failures = 0;

  hs_rr_arbiter #(.NUM_SRC(4), .DW(8), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .src_mask(src_mask), .req(req), .ack(ack),
    .data_o(data_o), .src_id(src_id), .busy(busy), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rstn = 1'b0;
    ack = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Runs one full handshake, acking dly cycles after req is seen; returns
  // what the link showed. ok=0 if any bounded wait expired.
  task automatic xfer(input int dly, output logic [3:0] rdy, output logic [1:0] id,
                      output logic [7:0] d, output bit ok);
    int n;
    ok = 0;
    id = 'x;
    d = 'x;
    #1;
    rdy = src_ready;
    n = 0;
    while (!req && n < 50) begin @(negedge clk); n++; end
    if (!req) return;
    id = src_id;
    d = data_o;
    repeat (dly) @(negedge clk);
    ack = 1'b1;
    n = 0;
    while (req && n < 50) begin @(negedge clk); n++; end
    ack = 1'b0;
    if (req) return;
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", src_ready); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_o); end
    checks++; if (src_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", src_id); end
    do_reset();
  endtask

  task automatic test_single();
    logic [3:0] rdy; logic [1:0] id; logic [7:0] d; bit ok;
    src_mask = 4'hf;
    src_data = 32'h443322A5;
    src_valid = 4'b0001;
    xfer(3, rdy, id, d, ok);
    src_valid = 4'b0000;
    checks++; if (rdy !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", rdy); end
    checks++; if (id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", id); end
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", d); end
    checks++; if (!ok) begin failures++; $display("FAIL single_handshake got=incomplete exp=busy_low"); end
    repeat (5) @(negedge clk);
    checks++; if (req !== 1'b0 || data_o !== 8'h00) begin failures++; $display("FAIL single_one_pulse req=%b data=%h exp=0/00", req, data_o); end
  endtask

  task automatic test_rr();
    logic [3:0] rdy; logic [1:0] id; logic [7:0] d; bit ok;
    logic [1:0] exp_id [5] = '{0, 1, 2, 3, 0};
    do_reset();
    src_mask = 4'hf;
    src_data = 32'h44332211;
    src_valid = 4'hf;
    for (int i = 0; i < 5; i++) begin
      xfer(1, rdy, id, d, ok);
      checks++; if (id !== exp_id[i] || !ok) begin failures++; $display("FAIL rr_id[%0d] got=%0d ok=%0d exp=%0d", i, id, ok, exp_id[i]); end
      checks++; if (rdy !== 4'b0001 << exp_id[i]) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, rdy, 4'b0001 << exp_id[i]); end
      checks++; if (d !== 8'h11 * (exp_id[i] + 1)) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, d, 8'h11 * (exp_id[i] + 1)); end
    end
    src_valid = 4'h0;
  endtask

  task automatic test_mask();
    logic [3:0] rdy; logic [1:0] id; logic [7:0] d; bit ok;
    logic [1:0] exp_id [4] = '{1, 3, 1, 3};
    src_mask = 4'b1010;
    src_valid = 4'hf;
    for (int i = 0; i < 4; i++) begin
      xfer(0, rdy, id, d, ok);
      checks++; if (id !== exp_id[i] || !ok) begin failures++; $display("FAIL mask_id[%0d] got=%0d ok=%0d exp=%0d", i, id, ok, exp_id[i]); end
    end
    src_valid = 4'h0;
    src_mask = 4'hf;
  endtask

  task automatic test_ack_idle();
    logic [3:0] rdy; logic [1:0] id; logic [7:0] d; bit ok;
    ack = 1'b1;
    repeat (3) @(negedge clk);
    src_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (src_ready !== 4'b0000 || req !== 1'b0) begin failures++; $display("FAIL ack_idle_hold[%0d] ready=%b req=%b exp=0000/0", i, src_ready, req); end
    end
    ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (src_ready !== 4'b0001) begin failures++; $display("FAIL ack_idle_release got=%b exp=0001", src_ready); end
    xfer(0, rdy, id, d, ok);
    src_valid = 4'b0000;
    checks++; if (id !== 2'd0 || !ok) begin failures++; $display("FAIL ack_idle_grant got=%0d ok=%0d exp=0", id, ok); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    src_mask = 4'hf;
    src_data = 32'h44332211;
    src_valid = 4'b0001;
    n = 0;
    while (!req && n < 20) begin @(negedge clk); n++; end
    src_valid = 4'b0000;
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL timeout_req_rise got=%b exp=1", req); end
    repeat (15) @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", err_timeout); end
    @(negedge clk);
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_set got=%b exp=1", err_timeout); end
    checks++; if (req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL timeout_keep_waiting req=%b busy=%b exp=1/1", req, busy); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", err_timeout); end
    ack = 1'b1;
    n = 0;
    while (req && n < 20) begin @(negedge clk); n++; end
    ack = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0 || req !== 1'b0) begin failures++; $display("FAIL timeout_drain busy=%b req=%b exp=0/0", busy, req); end
    src_valid = 4'b0001;
    n = 0;
    while (!req && n < 20) begin @(negedge clk); n++; end
    src_valid = 4'b0000;
    err_clr = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clr_held got=%b exp=0", err_timeout); end
    @(negedge clk);
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_set_wins got=%b exp=1", err_timeout); end
    err_clr = 1'b0;
    @(negedge clk);
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", err_timeout); end
    ack = 1'b1;
    n = 0;
    while (req && n < 20) begin @(negedge clk); n++; end
    ack = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset_mid();
    logic [3:0] rdy; logic [1:0] id; logic [7:0] d; bit ok;
    int n;
    src_mask = 4'hf;
    src_data = 32'h44332211;
    src_valid = 4'hf;
    n = 0;
    while (!req && n < 20) begin @(negedge clk); n++; end
    checks++; if (req !== 1'b1 || src_id !== 2'd1) begin failures++; $display("FAIL mid_grant req=%b id=%0d exp=1/1", req, src_id); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || busy !== 1'b0 || data_o !== 8'h00) begin failures++; $display("FAIL mid_async_reset req=%b busy=%b data=%h exp=0/0/00", req, busy, data_o); end
    @(negedge clk);
    rstn = 1'b1;
    xfer(0, rdy, id, d, ok);
    src_valid = 4'h0;
    checks++; if (id !== 2'd0 || d !== 8'h11 || !ok) begin failures++; $display("FAIL mid_after_reset id=%0d data=%h ok=%0d exp=0/11/1", id, d, ok); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_mask();
    test_ack_idle();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
